// File: rtl/wwd_result_checker_pkg.sv
// rtl/wwd_result_checker_pkg.sv - shared state and result encodings for the WWD result checker
package wwd_result_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Outcome of evaluating the current table entry in one RUN cycle
  typedef enum logic [1:0] {
    RES_NONE = 2'd0,
    RES_PASS = 2'd1,
    RES_FAIL = 2'd2,
    RES_MISS = 2'd3
  } res_e;

endpackage

// File: rtl/wwd_expect_table.sv
// rtl/wwd_expect_table.sv - checkpoint table: one sync write port, one async read port
module wwd_expect_table #(
  parameter int WORD_SIZE = 16,
  parameter int NUM_TEST  = 56,
  parameter int IDX_W     = 6
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [WORD_SIZE-1:0] wr_inst,
  input  logic [WORD_SIZE-1:0] wr_ans,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic [WORD_SIZE-1:0] rd_inst,
  output logic [WORD_SIZE-1:0] rd_ans
);

  localparam logic [IDX_W:0] NUM_TEST_W = (IDX_W+1)'(NUM_TEST);

  // Each entry packs {expected num_inst, expected output_port}
  logic [2*WORD_SIZE-1:0] mem [NUM_TEST];

  // Out-of-range writes are dropped; contents survive reset on purpose
  always_ff @(posedge clk) begin
    if (wr_en && ({1'b0, wr_idx} < NUM_TEST_W)) begin
      mem[wr_idx] <= {wr_inst, wr_ans};
    end
  end

  assign rd_inst = mem[rd_idx][2*WORD_SIZE-1:WORD_SIZE];
  assign rd_ans  = mem[rd_idx][WORD_SIZE-1:0];

endmodule

// File: rtl/wwd_result_checker.sv
// rtl/wwd_result_checker.sv - compares retired num_inst/output_port against a checkpoint table
module wwd_result_checker
  import wwd_result_checker_pkg::*;
#(
  parameter int WORD_SIZE    = 16,
  parameter int NUM_TEST     = 56,
  parameter int IDX_W        = 6,
  parameter int MAX_CYCLES   = 10000,
  parameter int CYC_W        = 16,
  parameter int STOP_ON_FAIL = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_en,
  input  logic [IDX_W-1:0]     load_idx,
  input  logic [WORD_SIZE-1:0] load_inst,
  input  logic [WORD_SIZE-1:0] load_ans,
  input  logic                 start,
  input  logic [WORD_SIZE-1:0] num_inst,
  input  logic [WORD_SIZE-1:0] output_port,
  input  logic                 is_halted,
  output logic                 done,
  output logic                 all_pass,
  output logic                 timed_out,
  output logic [IDX_W:0]       pass_count,
  output logic [IDX_W:0]       fail_count,
  output logic [IDX_W:0]       miss_count,
  output logic                 first_bad_vld,
  output logic [IDX_W-1:0]     first_bad_idx,
  output logic [WORD_SIZE-1:0] first_bad_val,
  output logic [CYC_W-1:0]     cycle_count
);

  localparam logic [IDX_W:0]   NUM_TEST_W = (IDX_W+1)'(NUM_TEST);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_TEST-1);
  localparam logic [CYC_W-1:0] CYC_LIMIT  = CYC_W'(MAX_CYCLES-1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W:0]       pass_q, pass_d;
  logic [IDX_W:0]       fail_q, fail_d;
  logic [IDX_W:0]       miss_q, miss_d;
  logic                 bad_vld_q, bad_vld_d;
  logic [IDX_W-1:0]     bad_idx_q, bad_idx_d;
  logic [WORD_SIZE-1:0] bad_val_q, bad_val_d;
  logic [CYC_W-1:0]     cyc_q, cyc_d;
  logic                 tout_q, tout_d;

  logic [WORD_SIZE-1:0] exp_inst;
  logic [WORD_SIZE-1:0] exp_ans;
  logic                 table_we;
  res_e                 res;

  // Table writes only while idle, and never in the cycle that starts a run
  assign table_we = load_en && (state_q == ST_IDLE) && !start;

  wwd_expect_table #(
    .WORD_SIZE (WORD_SIZE),
    .NUM_TEST  (NUM_TEST),
    .IDX_W     (IDX_W)
  ) u_table (
    .clk     (clk),
    .wr_en   (table_we),
    .wr_idx  (load_idx),
    .wr_inst (load_inst),
    .wr_ans  (load_ans),
    .rd_idx  (ptr_q),
    .rd_inst (exp_inst),
    .rd_ans  (exp_ans)
  );

  // Classify the entry at ptr against the current cpu observation
  always_comb begin
    res = RES_NONE;
    if (num_inst == exp_inst) begin
      res = (output_port == exp_ans) ? RES_PASS : RES_FAIL;
    end else if (num_inst > exp_inst) begin
      res = RES_MISS;
    end
  end

  // Next-state, pointer, counter and first-bad capture logic
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    miss_d    = miss_q;
    bad_vld_d = bad_vld_q;
    bad_idx_d = bad_idx_q;
    bad_val_d = bad_val_q;
    cyc_d     = cyc_q;
    tout_d    = tout_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_RUN;
          ptr_d     = '0;
          pass_d    = '0;
          fail_d    = '0;
          miss_d    = '0;
          bad_vld_d = 1'b0;
          bad_idx_d = '0;
          bad_val_d = '0;
          cyc_d     = '0;
          tout_d    = 1'b0;
        end
      end

      ST_RUN: begin
        cyc_d = (cyc_q == '1) ? cyc_q : cyc_q + 1'b1;

        case (res)
          RES_PASS: pass_d = pass_q + 1'b1;
          RES_FAIL: fail_d = fail_q + 1'b1;
          RES_MISS: miss_d = miss_q + 1'b1;
          default: ;
        endcase

        if ((res == RES_FAIL || res == RES_MISS) && !bad_vld_q) begin
          bad_vld_d = 1'b1;
          bad_idx_d = ptr_q;
          bad_val_d = (res == RES_FAIL) ? output_port : '0;
        end

        if (res != RES_NONE && ptr_q == LAST_IDX) begin
          // Last entry consumed: ptr stays on it so it never runs off the table
          state_d = ST_DONE;
        end else begin
          if (res != RES_NONE) begin
            ptr_d = ptr_q + 1'b1;
          end
          if (res == RES_FAIL && STOP_ON_FAIL != 0) begin
            state_d = ST_DONE;
          end else if (is_halted || cyc_d == CYC_LIMIT) begin
            // Everything from the advanced pointer onward was never reached
            state_d = ST_DONE;
            tout_d  = !is_halted;
            miss_d  = miss_d + (NUM_TEST_W - {1'b0, ptr_d});
            if (!bad_vld_d) begin
              bad_vld_d = 1'b1;
              bad_idx_d = ptr_d;
              bad_val_d = '0;
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      pass_q    <= '0;
      fail_q    <= '0;
      miss_q    <= '0;
      bad_vld_q <= 1'b0;
      bad_idx_q <= '0;
      bad_val_q <= '0;
      cyc_q     <= '0;
      tout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      miss_q    <= miss_d;
      bad_vld_q <= bad_vld_d;
      bad_idx_q <= bad_idx_d;
      bad_val_q <= bad_val_d;
      cyc_q     <= cyc_d;
      tout_q    <= tout_d;
    end
  end

  assign done          = (state_q == ST_DONE);
  assign all_pass      = done && (pass_q == NUM_TEST_W);
  assign timed_out     = tout_q;
  assign pass_count    = pass_q;
  assign fail_count    = fail_q;
  assign miss_count    = miss_q;
  assign first_bad_vld = bad_vld_q;
  assign first_bad_idx = bad_idx_q;
  assign first_bad_val = bad_val_q;
  assign cycle_count   = cyc_q;

endmodule

// File: tb/tb_wwd_result_checker.sv
// tb/tb_wwd_result_checker.sv - directed self-checking bench for wwd_result_checker
module tb_wwd_result_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_en;
  logic [1:0]  load_idx;
  logic [15:0] load_inst;
  logic [15:0] load_ans;
  logic        start;
  logic [15:0] num_inst;
  logic [15:0] output_port;
  logic        is_halted;

  // stop-on-fail instance
  logic        s_done, s_all_pass, s_timed_out, s_bad_vld;
  logic [2:0]  s_pass, s_fail, s_miss;
  logic [1:0]  s_bad_idx;
  logic [15:0] s_bad_val, s_cyc;

  // keep-going instance
  logic        k_done, k_all_pass, k_timed_out, k_bad_vld;
  logic [2:0]  k_pass, k_fail, k_miss;
  logic [1:0]  k_bad_idx;
  logic [15:0] k_bad_val, k_cyc;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wwd_result_checker #(
    .WORD_SIZE(16), .NUM_TEST(3), .IDX_W(2), .MAX_CYCLES(20), .CYC_W(16), .STOP_ON_FAIL(1)
  ) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_idx(load_idx), .load_inst(load_inst),
    .load_ans(load_ans), .start(start), .num_inst(num_inst), .output_port(output_port),
    .is_halted(is_halted), .done(s_done), .all_pass(s_all_pass), .timed_out(s_timed_out),
    .pass_count(s_pass), .fail_count(s_fail), .miss_count(s_miss), .first_bad_vld(s_bad_vld),
    .first_bad_idx(s_bad_idx), .first_bad_val(s_bad_val), .cycle_count(s_cyc)
  );

  wwd_result_checker #(
    .WORD_SIZE(16), .NUM_TEST(3), .IDX_W(2), .MAX_CYCLES(20), .CYC_W(16), .STOP_ON_FAIL(0)
  ) dut_nf (
    .clk(clk), .reset(reset), .load_en(load_en), .load_idx(load_idx), .load_inst(load_inst),
    .load_ans(load_ans), .start(start), .num_inst(num_inst), .output_port(output_port),
    .is_halted(is_halted), .done(k_done), .all_pass(k_all_pass), .timed_out(k_timed_out),
    .pass_count(k_pass), .fail_count(k_fail), .miss_count(k_miss), .first_bad_vld(k_bad_vld),
    .first_bad_idx(k_bad_idx), .first_bad_val(k_bad_val), .cycle_count(k_cyc)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [15:0] n, input logic [15:0] val);
    num_inst    = n;
    output_port = val;
    step();
  endtask

  task automatic do_start();
    start    = 1'b1;
    num_inst = 16'd0;
    step();
    start    = 1'b0;
  endtask

  // Correct answer for the loaded table {3:0, 5:0, 11:1}
  function automatic logic [15:0] good_val(input logic [15:0] n);
    return (n == 16'd11) ? 16'd1 : 16'd0;
  endfunction

  initial begin
    reset = 1'b1; load_en = 1'b0; load_idx = '0; load_inst = '0; load_ans = '0;
    start = 1'b0; num_inst = '0; output_port = '0; is_halted = 1'b0;
    step();
    step();
    reset = 1'b0;

    check("rst_done", s_done, 0);
    check("rst_pass", s_pass, 0);
    check("rst_cyc", s_cyc, 0);
    check("rst_bad_vld", s_bad_vld, 0);

    // Load table; the write during the start cycle must be ignored
    load_en = 1'b1;
    load_idx = 2'd0; load_inst = 16'd3;  load_ans = 16'd0; step();
    load_idx = 2'd1; load_inst = 16'd5;  load_ans = 16'd0; step();
    load_idx = 2'd2; load_inst = 16'd11; load_ans = 16'd1; step();
    load_idx = 2'd0; load_inst = 16'd7;  load_ans = 16'd9;
    do_start();
    load_en = 1'b0;
    check("t1_run_cyc0", s_cyc, 0);

    // T1: all entries pass, done exactly at the consume of entry 2
    for (int n = 0; n <= 10; n++) drive(16'(n), good_val(16'(n)));
    check("t1_not_done_yet", s_done, 0);
    check("t1_pass_mid", s_pass, 2);
    drive(16'd11, 16'd1);
    check("t1_done", s_done, 1);
    check("t1_all_pass", s_all_pass, 1);
    check("t1_pass", s_pass, 3);
    check("t1_cyc", s_cyc, 12);
    check("t1_nf_all_pass", k_all_pass, 1);
    drive(16'd20, 16'd5);
    check("t1_frozen_cyc", s_cyc, 12);
    check("t1_frozen_pass", s_pass, 3);

    // T2: wrong value at entry 1
    do_start();
    check("t2_cleared_pass", s_pass, 0);
    check("t2_cleared_done", s_done, 0);
    for (int n = 0; n <= 4; n++) drive(16'(n), 16'd0);
    drive(16'd5, 16'd2);
    check("t2_done", s_done, 1);
    check("t2_fail", s_fail, 1);
    check("t2_bad_idx", s_bad_idx, 1);
    check("t2_bad_val", s_bad_val, 16'd2);
    check("t2_all_pass", s_all_pass, 0);
    check("t2_cyc", s_cyc, 6);
    check("t2_nf_running", k_done, 0);
    check("t2_nf_bad_val", k_bad_val, 16'd2);
    for (int n = 6; n <= 11; n++) drive(16'(n), good_val(16'(n)));
    check("t2_nf_done", k_done, 1);
    check("t2_nf_pass", k_pass, 2);
    check("t2_nf_fail", k_fail, 1);
    check("t2_nf_all_pass", k_all_pass, 0);
    check("t2_frozen_cyc", s_cyc, 6);

    // T3: num_inst jumps 3->7 skipping entry 1
    do_start();
    for (int n = 0; n <= 3; n++) drive(16'(n), 16'd0);
    drive(16'd7, 16'd0);
    check("t3_miss", s_miss, 1);
    check("t3_bad_idx", s_bad_idx, 1);
    check("t3_bad_val", s_bad_val, 16'd0);
    check("t3_running", s_done, 0);
    for (int n = 8; n <= 11; n++) drive(16'(n), good_val(16'(n)));
    check("t3_done", s_done, 1);
    check("t3_pass", s_pass, 2);
    check("t3_nf_miss", k_miss, 1);

    // T4: halt after entry 0
    do_start();
    for (int n = 0; n <= 3; n++) drive(16'(n), 16'd0);
    check("t4_pass_pre", s_pass, 1);
    is_halted = 1'b1;
    drive(16'd4, 16'd0);
    is_halted = 1'b0;
    check("t4_done", s_done, 1);
    check("t4_pass", s_pass, 1);
    check("t4_miss", s_miss, 2);
    check("t4_all_pass", s_all_pass, 0);
    check("t4_timed_out", s_timed_out, 0);
    check("t4_bad_idx", s_bad_idx, 1);

    // T5: num_inst stuck at 0 until the cycle budget runs out
    do_start();
    for (int c = 1; c <= 18; c++) drive(16'd0, 16'd0);
    check("t5_not_done", s_done, 0);
    check("t5_cyc18", s_cyc, 18);
    drive(16'd0, 16'd0);
    check("t5_done", s_done, 1);
    check("t5_cyc", s_cyc, 19);
    check("t5_timed_out", s_timed_out, 1);
    check("t5_miss", s_miss, 3);
    check("t5_nf_miss", k_miss, 3);
    drive(16'd0, 16'd0);
    check("t5_frozen_cyc", s_cyc, 19);

    // T6: reset mid-run, then rerun with the retained table
    do_start();
    for (int n = 0; n <= 3; n++) drive(16'(n), 16'd0);
    check("t6_pass_pre", s_pass, 1);
    reset = 1'b1;
    drive(16'd4, 16'd0);
    reset = 1'b0;
    check("t6_rst_done", s_done, 0);
    check("t6_rst_pass", s_pass, 0);
    check("t6_rst_cyc", s_cyc, 0);
    check("t6_rst_bad_vld", s_bad_vld, 0);
    check("t6_rst_timed_out", s_timed_out, 0);
    drive(16'd5, 16'd0);
    check("t6_idle_holds", s_cyc, 0);
    do_start();
    for (int n = 0; n <= 11; n++) drive(16'(n), good_val(16'(n)));
    check("t6_done", s_done, 1);
    check("t6_all_pass", s_all_pass, 1);
    check("t6_pass", s_pass, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
